ram_rmw_bridge: RTL and testbench

Request/response bridge that sits directly upstream of the testbench single-port block RAM model, which has a full-word write enable and a 1-cycle registered read. It accepts byte-enabled load/store requests from the core-side memory port over a valid/ready handshake. It turns partial-word stores into read-modify-write sequences and returns one response per request. One request is in flight at a time.

---
 rtl/ram_rmw_bridge.sv | 170 +++++++++++++++++
 tb/tb_ram_rmw_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rmw_bridge.sv
// ram_rmw_bridge: byte-enabled load/store bridge in front of a single-port,
// full-word-write RAM with a 1-cycle registered read. Partial-word stores
// become read-modify-write sequences. One request is in flight at a time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready = IDLE and not rst)
//   req_addr/we/be/wdata     byte address, store flag, byte enables, store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        load data (0 for stores/errors), misalign error
//   ram_we/addr/din/dout     downstream RAM port (word-aligned byte address)
//
// Optional feature: define RAM_RMW_BRIDGE_ALIGN_CHECK_EN to reject requests
// with req_addr[1:0] != 0 (error response, no RAM access). Otherwise the low
// address bits are ignored and rsp_err stays 0.
module ram_rmw_bridge #(
   parameter int unsigned MEM_SIZE = 4096,
   parameter int unsigned ADDR_W   = $clog2(MEM_SIZE * 4)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   input  logic [3:0]        req_be,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   localparam int unsigned WORD_W = ADDR_W - 2;

   // Address width must cover the RAM depth exactly.
   if (ADDR_W != $clog2(MEM_SIZE * 4)) begin : g_cfg_mismatch
      $error("ram_rmw_bridge: ADDR_W does not match MEM_SIZE");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WR,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       din_q, din_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              ram_we_q, ram_we_d;
   logic              misaligned_c;
   logic [31:0]       merged_c;

`ifdef RAM_RMW_BRIDGE_ALIGN_CHECK_EN
   assign misaligned_c = (req_addr[1:0] != 2'b00);
`else
   logic unused_low_addr;
   assign misaligned_c    = 1'b0;
   assign unused_low_addr = ^req_addr[1:0];
`endif

   // Byte merge of latched store data over the word read back from RAM.
   always_comb begin
      merged_c = ram_dout;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) merged_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      din_d   = din_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr[ADDR_W-1:2];
               we_d    = req_we;
               be_d    = req_be;
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               err_d   = 1'b0;
               if (misaligned_c) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end else if (!req_we || (req_be != 4'h0 && req_be != 4'hF)) begin
                  state_d = RD;
               end else if (req_be == 4'hF) begin
                  state_d = WR;
                  din_d   = req_wdata;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RD:   state_d = CAP;
         CAP: begin
            if (we_q) begin
               state_d = WR;
               din_d   = merged_c;
            end else begin
               state_d = RESP;
               rdata_d = ram_dout;
            end
         end
         WR:   state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Strobes are registered so they line up with the state they belong to.
      valid_d  = (state_d == RESP);
      ram_we_d = (state_d == WR);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= 4'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         din_q    <= 32'h0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         ram_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         din_q    <= din_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         ram_we_q <= ram_we_d;
      end
   end

   assign req_ready = (state_q == IDLE) && !rst;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign ram_we    = ram_we_q;
   assign ram_din   = din_q;
   assign ram_addr  = {addr_q, 2'b00};

endmodule

// File: tb/tb_ram_rmw_bridge.sv
// tb_ram_rmw_bridge: self-checking bench for ram_rmw_bridge with a
// registered-read RAM model and a word-array reference model of memory.
module tb_ram_rmw_bridge;

   localparam int unsigned MEM_SIZE = 4096;
   localparam int unsigned ADDR_W   = 14;

   logic              clk, rst;
   logic              req_valid, req_ready, req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_be;
   logic [31:0]       req_wdata;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic [31:0]       rsp_rdata;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din, ram_dout;

   int checks = 0;
   int errors = 0;

   ram_rmw_bridge #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: full-word write, 1-cycle registered read; preload port for the bench.
   logic [31:0] mem [MEM_SIZE];
   logic        pre_we = 1'b0;
   int          pre_idx = 0;
   logic [31:0] pre_val = 32'h0;
   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (ram_we) mem[int'(ram_addr) / 4] <= ram_din;
      ram_dout <= mem[int'(ram_addr) / 4];
   end

   // Reference memory contents as the core should see them.
   logic [31:0] ref_mem [MEM_SIZE];

   // Results shared between the driver and the scenario tasks.
   logic [31:0] rd, din, erd, edin;
   logic        e, ee;
   int          lat, nwe, elat, enwe, waited;
   bit          stable, ready_after;

   task automatic preload(input int idx, input logic [31:0] v);
      pre_idx = idx; pre_val = v; pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
      ref_mem[idx] = v;
   endtask

   // Expected outcome of one request from the memory rules; updates ref_mem.
   function automatic void model(input logic [ADDR_W-1:0] a, input logic w, input logic [3:0] b,
                                 input logic [31:0] d);
      int idx = int'(a) / 4;
      erd = 32'h0; ee = 1'b0; enwe = 0; edin = 32'h0; elat = 1;
`ifdef RAM_RMW_BRIDGE_ALIGN_CHECK_EN
      if (int'(a) % 4 != 0) begin ee = 1'b1; return; end
`endif
      if (!w) begin
         erd = ref_mem[idx]; elat = 3;
      end else if (b != 4'h0) begin
         edin = ref_mem[idx];
         for (int i = 0; i < 4; i++) if (b[i]) edin[8*i +: 8] = d[8*i +: 8];
         ref_mem[idx] = edin;
         enwe = 1;
         elat = (b == 4'hF) ? 2 : 4;
      end
   endfunction

   // Drives one request and observes the response; called at a negedge.
   task automatic do_req(input logic [ADDR_W-1:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input int hold);
      waited = 0; lat = -1; nwe = 0; din = 32'h0; rd = 32'h0; e = 1'b0;
      stable = 1'b1; ready_after = 1'b0;
      while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
      if (!req_ready) return;
      req_valid = 1'b1; req_addr = a; req_we = w; req_be = b; req_wdata = d;
      rsp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0; req_addr = ADDR_W'($urandom); req_we = 1'($urandom);
      req_be = 4'($urandom); req_wdata = $urandom;
      for (int k = 1; k <= 20; k++) begin
         if (ram_we) begin nwe++; din = ram_din; end
         if (rsp_valid) begin lat = k; break; end
         @(negedge clk);
      end
      if (lat < 0) return;
      rd = rsp_rdata; e = rsp_err;
      if (hold > 0 && req_ready) stable = 1'b0;
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== rd || rsp_err !== e || req_ready || ram_we) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      ready_after = req_ready && !rsp_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || ram_din !== 32'h0) begin
         errors++; $display("FAIL reset_data rdata %h err %b din %h exp 0", rsp_rdata, rsp_err, ram_din); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_full_store_load();
      model(ADDR_W'(16), 1'b1, 4'hF, 32'hDEADBEEF);
      do_req(ADDR_W'(16), 1'b1, 4'hF, 32'hDEADBEEF, 0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL fs_latency got %0d exp 2", lat); end
      checks++; if (nwe !== 1 || din !== 32'hDEADBEEF) begin
         errors++; $display("FAIL fs_write pulses %0d din %h exp 1 deadbeef", nwe, din); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fs_rdata got %h exp 0", rd); end
      model(ADDR_W'(16), 1'b0, 4'h0, 32'h0);
      do_req(ADDR_W'(16), 1'b0, 4'h0, 32'h0, 0);
      checks++; if (lat !== 3) begin errors++; $display("FAIL ld_latency got %0d exp 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF || nwe !== 0) begin
         errors++; $display("FAIL ld_rdata got %h pulses %0d exp deadbeef 0", rd, nwe); end
   endtask

   task automatic test_byte_merge();
      preload(8, 32'h11223344);
      model(ADDR_W'(32), 1'b1, 4'b0010, 32'h0000AA00);
      do_req(ADDR_W'(32), 1'b1, 4'b0010, 32'h0000AA00, 0);
      checks++; if (lat !== 4) begin errors++; $display("FAIL merge_latency got %0d exp 4", lat); end
      checks++; if (nwe !== 1 || din !== 32'h1122AA44) begin
         errors++; $display("FAIL merge_din pulses %0d din %h exp 1 1122aa44", nwe, din); end
      model(ADDR_W'(32), 1'b0, 4'h0, 32'h0);
      do_req(ADDR_W'(32), 1'b0, 4'h0, 32'h0, 0);
      checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL merge_readback got %h exp 1122aa44", rd); end
   endtask

   task automatic test_be_zero();
      preload(12, 32'hCAFEF00D);
      model(ADDR_W'(48), 1'b1, 4'h0, 32'h12345678);
      do_req(ADDR_W'(48), 1'b1, 4'h0, 32'h12345678, 0);
      checks++; if (lat !== 1 || nwe !== 0) begin
         errors++; $display("FAIL be0_store latency %0d pulses %0d exp 1 0", lat, nwe); end
      do_req(ADDR_W'(48), 1'b0, 4'h0, 32'h0, 0);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL be0_readback got %h exp cafef00d", rd); end
   endtask

   task automatic test_backpressure();
      model(ADDR_W'(32), 1'b0, 4'h0, 32'h0);
      do_req(ADDR_W'(32), 1'b0, 4'h0, 32'h0, 5);
      checks++; if (lat !== 3 || rd !== erd) begin
         errors++; $display("FAIL bp_response latency %0d rdata %h exp 3 %h", lat, rd, erd); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", stable); end
      checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", ready_after); end
   endtask

   task automatic test_reset_mid_rmw();
      int pulses = 0, rsps = 0;
      preload(16, 32'h55555555);
      req_valid = 1'b1; req_addr = ADDR_W'(64); req_we = 1'b1; req_be = 4'b0100;
      req_wdata = 32'hA5A5A5A5; rsp_ready = 1'b1;
      @(negedge clk);                      // RD
      req_valid = 1'b0;
      @(negedge clk);                      // CAP
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (ram_we) pulses++;
         if (rsp_valid) rsps++;
         @(negedge clk);
      end
      checks++; if (pulses !== 0 || rsps !== 0) begin
         errors++; $display("FAIL rst_rmw_activity pulses %0d responses %0d exp 0 0", pulses, rsps); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw_ready got %b exp 1", req_ready); end
      checks++; if (mem[16] !== 32'h55555555) begin errors++; $display("FAIL rst_rmw_word got %h exp 55555555", mem[16]); end
      do_req(ADDR_W'(64), 1'b0, 4'h0, 32'h0, 0);
      checks++; if (rd !== 32'h55555555) begin errors++; $display("FAIL rst_rmw_readback got %h exp 55555555", rd); end
   endtask

   task automatic test_misaligned();
      model(ADDR_W'(19), 1'b0, 4'h0, 32'h0);
      do_req(ADDR_W'(19), 1'b0, 4'h0, 32'h0, 0);
`ifdef RAM_RMW_BRIDGE_ALIGN_CHECK_EN
      checks++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
         errors++; $display("FAIL misalign err %b rdata %h latency %0d exp 1 0 1", e, rd, lat); end
`else
      checks++; if (e !== 1'b0 || rd !== 32'hDEADBEEF || lat !== 3) begin
         errors++; $display("FAIL misalign err %b rdata %h latency %0d exp 0 deadbeef 3", e, rd, lat); end
`endif
   endtask

   task automatic test_back_to_back();
      model(ADDR_W'(16), 1'b0, 4'h0, 32'h0);
      do_req(ADDR_W'(16), 1'b0, 4'h0, 32'h0, 0);
      checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %b exp 1", ready_after); end
      model(ADDR_W'(20), 1'b1, 4'hF, 32'h0BADF00D);
      do_req(ADDR_W'(20), 1'b1, 4'hF, 32'h0BADF00D, 0);
      checks++; if (waited !== 0 || lat !== 2) begin
         errors++; $display("FAIL b2b_accept waited %0d latency %0d exp 0 2", waited, lat); end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      logic              w;
      logic [3:0]        b;
      logic [31:0]       d;
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      for (int n = 0; n < 60; n++) begin
         a = ADDR_W'($urandom_range(0, 63));
         w = 1'($urandom);
         b = 4'($urandom);
         d = $urandom;
         model(a, w, b, d);
         do_req(a, w, b, d, int'($urandom_range(0, 2)));
         checks++; if (rd !== erd || e !== ee || lat !== elat) begin
            errors++; $display("FAIL rnd%0d_rsp addr %h we %b be %h: rdata %h err %b lat %0d exp %h %b %0d",
                               n, a, w, b, rd, e, lat, erd, ee, elat); end
         checks++; if (nwe !== enwe || (enwe == 1 && din !== edin)) begin
            errors++; $display("FAIL rnd%0d_write pulses %0d din %h exp %0d %h", n, nwe, din, enwe, edin); end
         checks++; if (stable !== 1'b1 || ready_after !== 1'b1) begin
            errors++; $display("FAIL rnd%0d_handshake stable %b ready_after %b exp 1 1", n, stable, ready_after); end
      end
      for (int i = 0; i < 16; i++) begin
         checks++; if (mem[i] !== ref_mem[i]) begin
            errors++; $display("FAIL rnd_final_word%0d got %h exp %h", i, mem[i], ref_mem[i]); end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_be = 4'h0;
      req_wdata = 32'h0; rsp_ready = 1'b1;
      for (int i = 0; i < int'(MEM_SIZE); i++) ref_mem[i] = 32'h0;
      test_reset();
      test_full_store_load();
      test_byte_merge();
      test_be_zero();
      test_backpressure();
      test_reset_mid_rmw();
      test_misaligned();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
